// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the RV32I pipeline stage controller: FSM state encoding and
// the bundle of stage load/flush enables, with helpers that build each control pattern.
package pipeline_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    FAULT    = 2'b10
  } state_e;

  typedef struct packed {
    logic pc_load;
    logic ifid_load;
    logic idex_load;
    logic exmem_load;
    logic memwb_load;
    logic ifid_flush;
    logic idex_flush;
    logic memwb_flush;
  } ctrl_t;

  // Front of the pipe holds still; MEM/WB takes a bubble while memory is busy.
  function automatic ctrl_t freeze_ctrl();
    ctrl_t c;
    c = '0;
    c.memwb_load  = 1'b1;
    c.memwb_flush = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t issue_ctrl(input logic branch, input logic lu);
    ctrl_t c;
    c = '{pc_load: 1'b1, ifid_load: 1'b1, idex_load: 1'b1, exmem_load: 1'b1,
          memwb_load: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0, memwb_flush: 1'b0};
    if (branch) begin
      c.ifid_flush = 1'b1;
      c.idex_flush = 1'b1;
    end else if (lu) begin
      c.pc_load    = 1'b0;
      c.ifid_load  = 1'b0;
      c.idex_flush = 1'b1;
    end else begin
      c.memwb_flush = 1'b0;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare between the load in EX and the sources of the instruction in ID.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  output logic       lu
);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign lu = ex_mem_read & (ex_rd != 5'd0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2));

endmodule

// File: rtl/pipeline_ctrl.sv
// Stage controller for the 5-stage RV32I pipeline: load-use stall, branch flush, memory
// freeze with timeout fault. Optional perf counters are built when PIPE_PERF_EN is defined.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [4:0]   id_rs1,
  input  logic [4:0]   id_rs2,
  input  logic [4:0]   ex_rd,
  input  logic         ex_mem_read,
  input  logic         ex_branch_taken,
  input  logic         mem_req,
  input  logic         mem_ready,
  output logic         pc_load,
  output logic         ifid_load,
  output logic         idex_load,
  output logic         exmem_load,
  output logic         memwb_load,
  output logic         ifid_flush,
  output logic         idex_flush,
  output logic         memwb_flush,
  output logic [1:0]   state,
  output logic         timeout_err
`ifdef PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
`endif
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_err_q;
  logic              lu_s;
  ctrl_t             ctrl_s;

  hazard_detect u_hazard (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .lu          (lu_s)
  );

  always_comb begin
    ctrl_s     = '0;
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      RUN: begin
        if (mem_req && !mem_ready) begin
          ctrl_s     = freeze_ctrl();
          state_d    = MEM_WAIT;
          wait_cnt_d = '0;
        end else begin
          ctrl_s = issue_ctrl(ex_branch_taken, lu_s);
        end
      end
      MEM_WAIT: begin
        if (!mem_ready) begin
          ctrl_s = freeze_ctrl();
          if (wait_cnt_q == WAIT_LAST) begin
            state_d = FAULT;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end else begin
          // Release: the frozen EX instruction gets its branch/hazard decision now.
          ctrl_s  = issue_ctrl(ex_branch_taken, lu_s);
          state_d = RUN;
        end
      end
      default: begin
        ctrl_s  = '0;
        state_d = FAULT;
      end
    endcase
    if (clr) begin
      ctrl_s = '0;
    end else begin
      ctrl_s = ctrl_s;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_q | (state_d == FAULT);
    end
  end

  assign pc_load     = ctrl_s.pc_load;
  assign ifid_load   = ctrl_s.ifid_load;
  assign idex_load   = ctrl_s.idex_load;
  assign exmem_load  = ctrl_s.exmem_load;
  assign memwb_load  = ctrl_s.memwb_load;
  assign ifid_flush  = ctrl_s.ifid_flush;
  assign idex_flush  = ctrl_s.idex_flush;
  assign memwb_flush = ctrl_s.memwb_flush;
  assign state       = state_q;
  assign timeout_err = timeout_err_q;

`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0] stall_cycles_q, flush_count_q;
  logic             stall_evt_s, flush_evt_s;

  assign stall_evt_s = !ctrl_s.pc_load && (state_q == RUN || state_q == MEM_WAIT) && !clr;
  assign flush_evt_s = ctrl_s.ifid_flush;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (stall_evt_s && !(&stall_cycles_q)) begin
        stall_cycles_q <= stall_cycles_q + CNT_W'(1);
      end else begin
        stall_cycles_q <= stall_cycles_q;
      end
      if (flush_evt_s && !(&flush_count_q)) begin
        flush_count_q <= flush_count_q + CNT_W'(1);
      end else begin
        flush_count_q <= flush_count_q;
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed scenarios plus random traffic, checked
// against a behavioural model of the controller rules.
module tb_pipeline_ctrl;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       clr;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       ex_mem_read, ex_branch_taken, mem_req, mem_ready;
  logic       pc_load, ifid_load, idex_load, exmem_load, memwb_load;
  logic       ifid_flush, idex_flush, memwb_flush, timeout_err;
  logic [1:0] state;
`ifdef PIPE_PERF_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  pipeline_ctrl #(.MEM_TIMEOUT(T), .CNT_W(32)) dut (
    .clk(clk), .clr(clr), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_load(pc_load), .ifid_load(ifid_load), .idex_load(idex_load),
    .exmem_load(exmem_load), .memwb_load(memwb_load),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_flush(memwb_flush),
    .state(state), .timeout_err(timeout_err)
`ifdef PIPE_PERF_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  // expected vector: {pc,ifid,idex,exmem,memwb, ifid_f,idex_f,memwb_f, state[1:0], err}
  logic [10:0] exp_q[$];
  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int cyc_n  = 0;

  // model: mode 0=running, 1=waiting on memory, 2=faulted; waited = not-ready cycles seen
  int m_mode = 0;
  int m_waited = 0;

  task automatic model(input logic c, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic rd_ld, input logic br,
                       input logic req, input logic rdy, output logic [10:0] e);
    logic hz;
    logic [1:0] st;
    hz = rd_ld && (rd != 5'd0) && (rd == rs1 || rd == rs2);
    st = 2'(m_mode);
    if (c) begin
      e = 11'b0;
      m_mode = 0;
      m_waited = 0;
    end else if (m_mode == 2) begin
      e = {8'b0, 2'b10, 1'b1};
    end else if ((m_mode == 0 && req && !rdy) || (m_mode == 1 && !rdy)) begin
      e = {5'b00001, 3'b001, st, 1'b0};
      if (m_mode == 0) begin
        m_mode = 1;
        m_waited = 0;
      end else begin
        m_waited++;
        if (m_waited == T) m_mode = 2;
      end
    end else begin
      if (br)      e = {5'b11111, 3'b110, st, 1'b0};
      else if (hz) e = {5'b00111, 3'b010, st, 1'b0};
      else         e = {5'b11111, 3'b000, st, 1'b0};
      m_mode = 0;
    end
  endtask

  task automatic cyc(input logic c, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input logic rd_ld, input logic br,
                     input logic req, input logic rdy);
    logic [10:0] e;
    @(posedge clk);
    #1;
    clr = c; id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd; ex_mem_read = rd_ld;
    ex_branch_taken = br; mem_req = req; mem_ready = rdy;
    model(c, rs1, rs2, rd, rd_ld, br, req, rdy, e);
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic c);
    cyc(c, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // monitor: outputs are Mealy, so every cycle presents a response to check
  always @(negedge clk) begin
    logic [10:0] got, e;
    cyc_n++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = {pc_load, ifid_load, idex_load, exmem_load, memwb_load,
             ifid_flush, idex_flush, memwb_flush, state, timeout_err};
      checks++;
      if (got !== e) begin
        fails++;
        $display("FAIL outputs@cycle%0d: got %b expected %b", cyc_n, got, e);
      end else begin
        passes++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b1; id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    ex_mem_read = 1'b0; ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    idle(1'b1);
    idle(1'b0);
    // load-use, then x0 destination
    cyc(1'b0, 5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 5'd1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    // branch alone, then branch over a load-use hazard
    cyc(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    // memory wait 3 cycles then release, then a normal cycle
    repeat (3) cyc(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(1'b0);
    // req and ready together: no stall; release with a pending branch
    cyc(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 5'd7, 5'd2, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
    // timeout into FAULT; later ready is ignored; clr recovers
    repeat (T + 2) cyc(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b0);
    // clr in the middle of a memory wait
    repeat (2) cyc(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    // random traffic with occasional clr
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 39) == 0),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 4) < 2), 1'($urandom_range(0, 1)));
    end
    idle(1'b0);
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      fails++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
